// File: rtl/param_memory_if.sv
// Request/valid bus between a load-store master and the param_memory data RAM.
// One read port and one write port, each usable every cycle.
interface param_memory_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
);

  logic                      MRead_request;
  logic                      MWrite_request;
  logic [ADDR_WIDTH-1:0]     read_adress;
  logic [ADDR_WIDTH-1:0]     write_adress;
  logic [DATA_WIDTH-1:0]     write_data;
  logic [DATA_WIDTH/8-1:0]   write_mask;
  logic [DATA_WIDTH-1:0]     read_data;
  logic                      read_valid;
  logic                      mem_ready;
  logic                      addr_error;

  modport master (
    output MRead_request, MWrite_request, read_adress, write_adress,
           write_data, write_mask,
    input  read_data, read_valid, mem_ready, addr_error
  );

  modport slave (
    input  MRead_request, MWrite_request, read_adress, write_adress,
           write_data, write_mask,
    output read_data, read_valid, mem_ready, addr_error
  );

endinterface

// File: rtl/param_memory.sv
// Parametrised 1R1W synchronous data RAM with byte-lane write masking,
// selectable read-during-write behaviour and a hardware clear after reset.
module param_memory #(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 10,
  parameter int                    DEPTH      = 1000,
  parameter int                    RDW_MODE   = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic           clk,
  input  logic           rst,
  param_memory_if.slave  bus
);

  localparam int                    LP_LANES = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0]   LP_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LP_LAST  = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  state_e                r_state;
  state_e                w_state_next;
  logic [ADDR_WIDTH-1:0] r_clear_cnt;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_read_data;
  logic                  r_read_valid;
  logic                  r_addr_error;

  logic                  w_ready;
  logic                  w_rd_acc;
  logic                  w_wr_acc;
  logic                  w_rd_in_range;
  logic                  w_wr_in_range;
  logic                  w_wr_commit;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic [DATA_WIDTH-1:0] w_wr_old;
  logic [DATA_WIDTH-1:0] w_wr_merged;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    case (r_state)
      ST_CLEAR: if (r_clear_cnt == LP_LAST) w_state_next = ST_IDLE;
      ST_IDLE:  w_ready = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_CLEAR;
      r_clear_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_CLEAR)
        r_clear_cnt <= (r_clear_cnt == LP_LAST) ? '0 : r_clear_cnt + 1'b1;
    end
  end

  assign w_rd_acc      = w_ready && bus.MRead_request;
  assign w_wr_acc      = w_ready && bus.MWrite_request;
  assign w_rd_in_range = {1'b0, bus.read_adress}  < LP_DEPTH;
  assign w_wr_in_range = {1'b0, bus.write_adress} < LP_DEPTH;
  assign w_wr_commit   = w_wr_acc && w_wr_in_range;
  assign w_rd_word     = r_mem[bus.read_adress];
  assign w_wr_old      = r_mem[bus.write_adress];

  // Lanes with a clear mask bit keep the stored byte.
  always_comb begin
    w_wr_merged = w_wr_old;
    for (int i = 0; i < LP_LANES; i++) begin
      if (bus.write_mask[i]) w_wr_merged[8*i +: 8] = bus.write_data[8*i +: 8];
    end
  end

  // NOTE: the array has no reset; the post-reset clear sweep gives it defined contents.
  always_ff @(posedge clk) begin
    if (r_state == ST_CLEAR)
      r_mem[r_clear_cnt] <= INIT_VALUE;
    else if (w_wr_commit)
      r_mem[bus.write_adress] <= w_wr_merged;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_read_data  <= '0;
      r_read_valid <= 1'b0;
      r_addr_error <= 1'b0;
    end else begin
      r_read_valid <= w_rd_acc;
      r_addr_error <= (w_rd_acc && !w_rd_in_range) || (w_wr_acc && !w_wr_in_range);
      if (w_rd_acc) begin
        if (!w_rd_in_range)
          r_read_data <= '0;
        else if (RDW_MODE != 0 && w_wr_commit && bus.write_adress == bus.read_adress)
          r_read_data <= w_wr_merged;
        else
          r_read_data <= w_rd_word;
      end
    end
  end

  assign bus.read_data  = r_read_data;
  assign bus.read_valid = r_read_valid;
  assign bus.mem_ready  = w_ready;
  assign bus.addr_error = r_addr_error;

endmodule

// File: tb/tb_param_memory.sv
// Self-checking bench: one old-data and one new-data RDW instance driven in lockstep,
// compared against an array-based reference model of the memory.
module tb_param_memory;

  localparam int DW    = 16;
  localparam int AW    = 10;
  localparam int DEPTH = 1000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          d_rd, d_wr;
  logic [AW-1:0] d_ra, d_wa;
  logic [DW-1:0] d_wd;
  logic [1:0]    d_wm;

  param_memory_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus0 ();
  param_memory_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();

  assign bus0.MRead_request  = d_rd;
  assign bus0.MWrite_request = d_wr;
  assign bus0.read_adress    = d_ra;
  assign bus0.write_adress   = d_wa;
  assign bus0.write_data     = d_wd;
  assign bus0.write_mask     = d_wm;
  assign bus1.MRead_request  = d_rd;
  assign bus1.MWrite_request = d_wr;
  assign bus1.read_adress    = d_ra;
  assign bus1.write_adress   = d_wa;
  assign bus1.write_data     = d_wd;
  assign bus1.write_mask     = d_wm;

  param_memory #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .RDW_MODE(0), .INIT_VALUE(16'h0000)
  ) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave)
  );

  param_memory #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .RDW_MODE(1), .INIT_VALUE(16'h0000)
  ) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model_mem [DEPTH];
  bit            written   [DEPTH];
  bit            model_ready;
  logic [DW-1:0] exp_rd0, exp_rd1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit rd, input int ra, input bit wr, input int wa,
                       input logic [DW-1:0] wd, input logic [1:0] wm);
    d_rd = rd;
    d_ra = AW'(ra);
    d_wr = wr;
    d_wa = AW'(wa);
    d_wd = wd;
    d_wm = wm;
  endtask

  task automatic model_reset();
    for (int a = 0; a < DEPTH; a++) model_mem[a] = '0;
    exp_rd0     = '0;
    exp_rd1     = '0;
    model_ready = 1'b0;
  endtask

  // One clock with the currently driven inputs; model predicts, then outputs are checked.
  task automatic tick(input string tag);
    bit            ev, ee;
    logic [DW-1:0] old_word;
    ev = 1'b0;
    ee = 1'b0;
    if (model_ready) begin
      ev = d_rd;
      ee = (d_rd && int'(d_ra) >= DEPTH) || (d_wr && int'(d_wa) >= DEPTH);
      old_word = (d_rd && int'(d_ra) < DEPTH) ? model_mem[d_ra] : '0;
      if (d_wr && int'(d_wa) < DEPTH) begin
        for (int l = 0; l < DW / 8; l++)
          if (d_wm[l]) model_mem[d_wa][8*l +: 8] = d_wd[8*l +: 8];
        written[d_wa] = 1'b1;
      end
      if (d_rd) begin
        exp_rd0 = old_word;
        exp_rd1 = (int'(d_ra) < DEPTH) ? model_mem[d_ra] : '0;
      end
    end
    @(posedge clk);
    #1;
    check({tag, " valid"}, {bus0.read_valid, bus1.read_valid}, {ev, ev});
    check({tag, " err"},   {bus0.addr_error, bus1.addr_error}, {ee, ee});
    check({tag, " ready"}, {bus0.mem_ready,  bus1.mem_ready},  {model_ready, model_ready});
    check({tag, " data0"}, bus0.read_data, exp_rd0);
    check({tag, " data1"}, bus1.read_data, exp_rd1);
  endtask

  // Called just after rst is released; the DUT must stay quiet for DEPTH-1 edges.
  task automatic wait_clear();
    bit bad;
    bad = 1'b0;
    for (int e = 1; e <= DEPTH; e++) begin
      @(posedge clk);
      #1;
      if (e < DEPTH)
        bad |= bus0.mem_ready | bus1.mem_ready | bus0.read_valid | bus1.read_valid |
               bus0.addr_error | bus1.addr_error;
    end
    check("clear quiet", bad, 0);
    check("ready at DEPTH", {bus0.mem_ready, bus1.mem_ready}, 2'b11);
    check("no valid at DEPTH", {bus0.read_valid, bus1.read_valid}, 2'b00);
    model_ready = 1'b1;
  endtask

  function automatic int pick_addr();
    if ($urandom_range(0, 15) == 0) return int'($urandom_range(DEPTH, 1023));
    return int'($urandom_range(0, 31));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < DEPTH; a++) written[a] = 1'b0;
    model_reset();
    rst = 1'b0;
    drive(1, 5, 0, 0, '0, '0);
    #3;
    check("reset data",  {bus0.read_data, bus1.read_data}, 0);
    check("reset flags", {bus0.read_valid, bus1.read_valid, bus0.mem_ready,
                          bus1.mem_ready, bus0.addr_error, bus1.addr_error}, 0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    wait_clear();
    tick("first read");
    check("first read value", {bus0.read_valid, bus0.read_data}, {1'b1, 16'h0000});

    // Masked write
    drive(0, 0, 1, 5, 16'h1234, 2'b11);
    tick("mask wr1");
    drive(0, 0, 1, 5, 16'hABCD, 2'b10);
    tick("mask wr2");
    drive(1, 5, 0, 0, '0, '0);
    tick("mask rd");
    check("masked value", {bus0.read_data, bus1.read_data}, {16'hAB34, 16'hAB34});

    // Read during write
    drive(0, 0, 1, 10, 16'h0021, 2'b11);
    tick("rdw init");
    drive(1, 10, 1, 10, 16'h0033, 2'b11);
    tick("rdw");
    check("rdw mode0", bus0.read_data, 16'h0021);
    check("rdw mode1", bus1.read_data, 16'h0033);
    drive(1, 10, 0, 0, '0, '0);
    tick("rdw next");
    check("rdw next value", {bus0.read_data, bus1.read_data}, {16'h0033, 16'h0033});

    // Out of range
    drive(0, 0, 1, 1000, 16'hFFFF, 2'b11);
    tick("oor wr");
    check("oor wr err", {bus0.addr_error, bus1.addr_error}, 2'b11);
    drive(1, 1000, 0, 0, '0, '0);
    tick("oor rd");
    check("oor rd value", {bus0.read_valid, bus0.addr_error, bus0.read_data}, {2'b11, 16'h0000});
    drive(1, 999, 0, 0, '0, '0);
    tick("rd 999");
    check("rd 999 value", {bus0.addr_error, bus0.read_data}, {1'b0, 16'h0000});
    drive(1, 1000, 1, 1023, 16'h5555, 2'b11);
    tick("oor both");
    drive(0, 0, 0, 0, '0, '0);
    tick("idle");

    // Streaming
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 1, i, 16'h0100 + 16'(i), 2'b11);
      tick("stream wr");
    end
    for (int i = 0; i < 8; i++) begin
      drive(1, i, 0, 0, '0, '0);
      tick("stream rd");
      check("stream value", {bus0.read_valid, bus0.read_data}, {1'b1, 16'h0100 + 16'(i)});
    end

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      int ra;
      int wa;
      ra = pick_addr();
      wa = ($urandom_range(0, 3) == 0) ? ra : pick_addr();
      drive(bit'($urandom_range(0, 1)), ra, bit'($urandom_range(0, 1)), wa,
            DW'($urandom), 2'($urandom_range(0, 3)));
      tick("rand");
    end

    // Reset during a read, then again halfway through the clear
    drive(1, 5, 0, 0, '0, '0);
    tick("pre-reset rd");
    #2;
    rst = 1'b0;
    #1;
    check("async rst flags", {bus0.read_valid, bus1.read_valid, bus0.mem_ready,
                              bus1.mem_ready, bus0.addr_error, bus1.addr_error}, 0);
    check("async rst data", {bus0.read_data, bus1.read_data}, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (500) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("mid-clear rst ready", {bus0.mem_ready, bus1.mem_ready}, 2'b00);
    @(posedge clk);
    #1;
    rst = 1'b1;
    wait_clear();
    for (int a = 0; a < DEPTH; a++) begin
      if (written[a]) begin
        drive(1, a, 0, 0, '0, '0);
        tick("post-reset rd");
        check("post-reset zero", bus0.read_data, 16'h0000);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
